// File: rtl/alu_operand_regfile.sv
// Register file and registered operand-issue stage feeding the bitwise ALU slices.
// Provides R2/R3 snapshot operands with a valid/ready handshake and write-to-read bypass.
module alu_operand_regfile #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_req,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rs2_addr,
    input  logic [ADDR_W-1:0] rs3_addr,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [WIDTH-1:0]  R2_out,
    output logic [WIDTH-1:0]  R3_out,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] regs [DEPTH];
    logic             wr_hit;
    logic             issue;
    logic [WIDTH-1:0] rd2_val;
    logic [WIDTH-1:0] rd3_val;

    // Out-of-range addresses never write, so they also never bypass.
    assign wr_hit   = wr_en && ({1'b0, wr_addr} < DEPTH_L);
    assign rd_ready = !op_valid || op_ready;
    assign issue    = rd_req && rd_ready;

    always_comb begin
        rd2_val = '0;
        rd3_val = '0;
        if ({1'b0, rs2_addr} < DEPTH_L) begin
            rd2_val = (wr_hit && wr_addr == rs2_addr) ? wr_data : regs[rs2_addr];
        end
        if ({1'b0, rs3_addr} < DEPTH_L) begin
            rd3_val = (wr_hit && wr_addr == rs3_addr) ? wr_data : regs[rs3_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            op_valid <= 1'b0;
            R2_out   <= '0;
            R3_out   <= '0;
        end else begin
            if (wr_hit) begin
                regs[wr_addr] <= wr_data;
            end
            if (issue) begin
                op_valid <= 1'b1;
                R2_out   <= rd2_val;
                R3_out   <= rd3_val;
            end else if (op_ready) begin
                op_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_operand_regfile.sv
// Scoreboard bench for alu_operand_regfile: directed plan followed by random traffic,
// instantiated with DEPTH=6 so out-of-range addresses 6 and 7 are exercised.
module tb_alu_operand_regfile;

    localparam int W = 8;
    localparam int D = 6;
    localparam int A = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         rd_req = 1'b0;
    logic         rd_ready;
    logic [A-1:0] rs2_addr = '0;
    logic [A-1:0] rs3_addr = '0;
    logic         op_valid;
    logic         op_ready = 1'b0;
    logic [W-1:0] R2_out;
    logic [W-1:0] R3_out;
    logic         wr_en = 1'b0;
    logic [A-1:0] wr_addr = '0;
    logic [W-1:0] wr_data = '0;

    always #5 clk = ~clk;

    alu_operand_regfile #(.WIDTH(W), .DEPTH(D), .ADDR_W(A)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_req   (rd_req),
        .rd_ready (rd_ready),
        .rs2_addr (rs2_addr),
        .rs3_addr (rs3_addr),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .R2_out   (R2_out),
        .R3_out   (R3_out),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
    } pair_t;

    int           checks = 0;
    int           failures = 0;
    logic [W-1:0] mem [8];
    bit           m_valid = 1'b0;
    pair_t        sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_read(input int a, input bit we, input int wa,
                                              input logic [W-1:0] wd);
        if (a >= D) return '0;
        if (we && wa == a) return wd;
        return mem[a];
    endfunction

    // One clock of stimulus; model state advances only after the edge so the
    // negedge monitor always sees the model matching the DUT's registered state.
    task automatic step(input bit req, input int a2, input int a3, input bit ordy,
                        input bit we, input int wa, input logic [W-1:0] wd);
        bit    exp_ready;
        bit    iss;
        bit    nv;
        pair_t p;
        rst_n    = 1'b1;
        rd_req   = req;
        rs2_addr = A'(a2);
        rs3_addr = A'(a3);
        op_ready = ordy;
        wr_en    = we;
        wr_addr  = A'(wa);
        wr_data  = wd;
        #1;
        exp_ready = !m_valid || ordy;
        check("rd_ready", 32'(rd_ready), 32'(exp_ready));
        iss = req && exp_ready;
        p.a = ref_read(a2, we, wa, wd);
        p.b = ref_read(a3, we, wa, wd);
        nv  = iss ? 1'b1 : (ordy ? 1'b0 : m_valid);
        @(posedge clk);
        m_valid = nv;
        if (iss) sb.push_back(p);
        if (we && wa < D) mem[wa] = wd;
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        rd_req   = 1'b1;
        wr_en    = 1'b1;
        wr_addr  = 3'd1;
        wr_data  = 8'hEE;
        rs2_addr = 3'd1;
        rs3_addr = 3'd1;
        op_ready = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 8; i++) mem[i] = '0;
        m_valid = 1'b0;
        sb.delete();
        #1;
        check("reset_R2", 32'(R2_out), 32'h0);
        check("reset_R3", 32'(R3_out), 32'h0);
    endtask

    initial begin : monitor
        pair_t p;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("op_valid", 32'(op_valid), 32'(m_valid));
                if (op_valid === 1'b1 && op_ready === 1'b1) begin
                    if (sb.size() == 0) begin
                        check("sb_nonempty", 32'(sb.size()), 32'h1);
                    end else begin
                        p = sb.pop_front();
                        check("R2_out", 32'(R2_out), 32'(p.a));
                        check("R3_out", 32'(R3_out), 32'(p.b));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog actual=timeout expected=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin : stim
        for (int i = 0; i < 8; i++) mem[i] = '0;
        do_reset();
        // first issue after reset reads zeros
        step(1, 1, 2, 1, 0, 0, 8'h00);
        step(0, 0, 0, 1, 1, 3, 8'hA5);
        step(1, 3, 3, 1, 0, 0, 8'h00);
        step(0, 0, 0, 1, 1, 5, 8'h11);
        // same-cycle write bypass
        step(1, 4, 5, 1, 1, 4, 8'h3C);
        // backpressure with a write to a held source
        step(1, 3, 5, 1, 0, 0, 8'h00);
        for (int i = 0; i < 3; i++) step(1, 3, 5, 0, 1, 3, 8'hFF);
        step(1, 3, 5, 1, 0, 0, 8'h00);
        step(0, 0, 0, 1, 0, 0, 8'h00);
        // streaming then drain
        for (int i = 0; i < 4; i++) step(1, i, i + 1, 1, 0, 0, 8'h00);
        step(0, 0, 0, 1, 0, 0, 8'h00);
        step(0, 0, 0, 0, 0, 0, 8'h00);
        // out-of-range write/read, including a would-be bypass
        step(0, 0, 0, 1, 1, 7, 8'h55);
        step(1, 7, 7, 1, 0, 0, 8'h00);
        step(1, 7, 6, 1, 1, 6, 8'hAA);
        step(1, 3, 4, 0, 0, 0, 8'h00);
        // reset while a pair is held, then everything reads back zero
        do_reset();
        step(1, 3, 4, 1, 0, 0, 8'h00);
        step(1, 5, 0, 1, 0, 0, 8'h00);
        step(0, 0, 0, 1, 0, 0, 8'h00);
        // random traffic
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
            end else begin
                step(bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 7)), bit'($urandom_range(0, 2) != 0),
                     bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                     W'($urandom));
            end
        end
        step(0, 0, 0, 1, 0, 0, 8'h00);
        step(0, 0, 0, 1, 0, 0, 8'h00);
        @(negedge clk);
        #1;
        check("sb_empty", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
